// File: rtl/mux16_pkg.sv
// Shared word type, width and reset constant for the 16-bit word selector.
package mux16_pkg;
   localparam int WIDTH = 16;
   typedef logic [WIDTH-1:0] word_t;
   localparam word_t WORD_RST = 16'h0000;
endpackage

// File: rtl/mux2.sv
// One-bit 2:1 multiplexer built only from NAND gates: out = sel ? b : a.
module mux2 (
   input  logic a,
   input  logic b,
   input  logic sel,
   output logic out
);
   wire sel_n;
   wire pick_a_n;
   wire pick_b_n;
   wire out_w;

   nand g_inv   (sel_n,    sel,      sel);
   nand g_a     (pick_a_n, a,        sel_n);
   nand g_b     (pick_b_n, b,        sel);
   nand g_out   (out_w,    pick_a_n, pick_b_n);

   assign out = out_w;
endmodule

// File: rtl/mux_16.sv
// 16-bit word selector: NAND-level combinational output plus a one-cycle registered copy.
// Optional registered even parity of the registered word when MUX16_PARITY_EN is defined.
module mux_16
   import mux16_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q,
   output logic             out_par
);
   wire [WIDTH-1:0] mux_w;
   word_t           word_d;
   word_t           word_q;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         mux2 u_mux2 (
            .a   (a[gi]),
            .b   (b[gi]),
            .sel (sel),
            .out (mux_w[gi])
         );
      end
   endgenerate

   assign out = mux_w;

   always_comb begin
      word_d = mux_w;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word_q <= WORD_RST;
      end else begin
         word_q <= word_d;
      end
   end

   assign out_q = word_q;

`ifdef MUX16_PARITY_EN
   // Parity is taken from the incoming word so it lines up with word_q.
   logic par_d;
   logic par_q;

   always_comb begin
      par_d = ^mux_w;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end

   assign out_par = par_q;
`else
   assign out_par = 1'b0;
`endif
endmodule

// File: tb/tb_mux_16.sv
// Self-checking bench for mux_16: reference model plus directed vectors and an exhaustive per-bit sweep.
module tb_mux_16;
   logic        clk;
   logic        rst_n;
   logic [15:0] a;
   logic [15:0] b;
   logic        sel;
   logic [15:0] out;
   logic [15:0] out_q;
   logic        out_par;

   int vectors     = 0;
   int miscompares = 0;

   logic [15:0] exp_q;
   logic        model_valid = 1'b0;

`ifdef MUX16_PARITY_EN
   localparam bit PAR_ON = 1'b1;
`else
   localparam bit PAR_ON = 1'b0;
`endif

   mux_16 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a),
      .b       (b),
      .sel     (sel),
      .out     (out),
      .out_q   (out_q),
      .out_par (out_par)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: selected word, cleared or loaded at each edge
   always @(posedge clk) begin
      if (!rst_n) exp_q = 16'h0000;
      else        exp_q = sel ? b : a;
      model_valid = 1'b1;
   end

   always @(negedge clk) begin
      if (model_valid) begin
         chk("cycle_out",   out,   sel ? b : a);
         chk("cycle_out_q", out_q, exp_q);
         chk("cycle_par",   {15'd0, out_par}, {15'd0, PAR_ON ? ^exp_q : 1'b0});
      end
   end

   // Inputs change 2 time units after a rising edge, away from both edges
   task automatic apply(input logic r, input logic [15:0] av, input logic [15:0] bv, input logic s);
      @(posedge clk);
      #2;
      rst_n = r;
      a     = av;
      b     = bv;
      sel   = s;
      $display("apply rst_n=%0b a=%h b=%h sel=%0b", r, av, bv, s);
   endtask

   task automatic settle_edge();
      @(posedge clk);
      #2;
   endtask

   logic [7:0]  truth;
   logic [15:0] rnd;

   initial begin
      rst_n = 1'b0;
      a     = 16'hAAAA;
      b     = 16'h5555;
      sel   = 1'b0;
      truth = 8'b1010_1100;

      // Reset: registers clear, combinational path still live
      settle_edge();
      settle_edge();
      chk("rst_out_q", out_q, 16'h0000);
      chk("rst_par",   {15'd0, out_par}, 16'h0000);
      chk("rst_out",   out, 16'hAAAA);

      apply(1'b1, 16'hAAAA, 16'h5555, 1'b0);
      #1 chk("sel0_out", out, 16'hAAAA);
      chk("sel0_out_q_before", out_q, 16'h0000);
      settle_edge();
      chk("sel0_out_q", out_q, 16'hAAAA);

      apply(1'b1, 16'hAAAA, 16'h5555, 1'b1);
      #1 chk("sel1_out", out, 16'h5555);
      chk("sel1_out_q_before", out_q, 16'hAAAA);
      settle_edge();
      chk("sel1_out_q", out_q, 16'h5555);

      apply(1'b1, 16'h0000, 16'hFFFF, 1'b0);
      #1 chk("tog0_out", out, 16'h0000);
      apply(1'b1, 16'h0000, 16'hFFFF, 1'b1);
      #1 chk("tog1_out", out, 16'hFFFF);
      chk("tog0_out_q", out_q, 16'h0000);
      settle_edge();
      chk("tog1_out_q", out_q, 16'hFFFF);

      // Mid-stream reset for one edge
      apply(1'b0, 16'h0000, 16'hFFFF, 1'b1);
      settle_edge();
      chk("mid_rst_out_q", out_q, 16'h0000);
      chk("mid_rst_par",   {15'd0, out_par}, 16'h0000);
      chk("mid_rst_out",   out, 16'hFFFF);
      rst_n = 1'b1;
      settle_edge();
      chk("release_out_q", out_q, 16'hFFFF);

      apply(1'b1, 16'h0001, 16'hF0F0, 1'b0);
      settle_edge();
      chk("par_0001_q",   out_q, 16'h0001);
      chk("par_0001",     {15'd0, out_par}, {15'd0, PAR_ON});
      apply(1'b1, 16'h0003, 16'hF0F0, 1'b0);
      settle_edge();
      chk("par_0003",     {15'd0, out_par}, 16'h0000);
      apply(1'b1, 16'h1234, 16'h0007, 1'b1);
      settle_edge();
      chk("par_0007",     {15'd0, out_par}, {15'd0, PAR_ON});

      // Every bit position against the mux truth table, other bits randomised
      for (int bitpos = 0; bitpos < 16; bitpos++) begin
         for (int combo = 0; combo < 8; combo++) begin
            @(posedge clk);
            #2;
            rnd = 16'($urandom);
            a   = rnd;
            rnd = 16'($urandom);
            b   = rnd;
            a[bitpos] = combo[1];
            b[bitpos] = combo[0];
            sel       = combo[2];
            $display("apply bit=%0d sel=%0b a_bit=%0b b_bit=%0b", bitpos, combo[2], combo[1], combo[0]);
            #1 chk("truth_bit", {15'd0, out[bitpos]}, {15'd0, truth[combo]});
         end
      end

      settle_edge();
      settle_edge();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
